// File: rtl/cella_pkg.sv
// Shared definitions for the CELLA array control slice.
// This package holds the op codes, the sequencer state encoding and the default widths.
package cella_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    localparam logic [1:0] OP_MAC   = 2'd0;
    localparam logic [1:0] OP_CAM   = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRECH = 3'd1;
    localparam logic [2:0] ST_DRIVE = 3'd2;
    localparam logic [2:0] ST_SENSE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/cella_phase_timer.sv
// Loadable down-counter that times the precharge and drive phases.
// A load takes priority over the decrement, and the counter stops at zero.
module cella_phase_timer #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cella_op_ctrl.sv
// Command sequencer for the CELLA column array.
// It runs MAC, CAM and WRITE commands through the precharge, drive and sense phases.
module cella_op_ctrl
    import cella_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PRE_CYC  = 2,
    parameter int EVAL_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     w_en,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        data,
    output logic [(1<<ADDR_W)-1:0]   wl_en,
    output logic                     pre_en,
    output logic                     sa_en,
    input  logic [DATA_W-1:0]        sa_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err
);

    localparam int ROWS = 1 << ADDR_W;
    localparam int unsigned MAXC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
    localparam int unsigned CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] EVAL_LD = CW'(EVAL_CYC - 1);

    logic [2:0]      state;
    logic [1:0]      op_q;
    logic            timer_load;
    logic [CW-1:0]   timer_val;
    logic            timer_done;
    logic [ROWS-1:0] wl_drive;

    assign cmd_ready = (state == ST_IDLE);

    cella_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        timer_load = 1'b0;
        timer_val  = PRE_LD;
        if (state == ST_IDLE && cmd_valid && cmd_op != OP_RSVD) begin
            timer_load = 1'b1;
        end else if (state == ST_PRECH && timer_done) begin
            timer_load = 1'b1;
            timer_val  = EVAL_LD;
        end
    end

    always_comb begin
        wl_drive = '0;
        case (op_q)
            OP_MAC:   wl_drive = '1;
            OP_WRITE: wl_drive[addr] = 1'b1;
            default:  wl_drive = '0;
        endcase
    end

    // Strobes are registered from the current state, so they lag the state by one cycle.
    // RESP therefore spends one cycle capturing sa_out before it raises rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_MAC;
            w_en      <= 1'b1;
            addr      <= '0;
            data      <= '0;
            wl_en     <= '0;
            pre_en    <= 1'b0;
            sa_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            pre_en <= (state == ST_PRECH);
            sa_en  <= (state == ST_SENSE);
            if (state == ST_DRIVE) begin
                wl_en <= wl_drive;
            end else if (state != ST_SENSE) begin
                wl_en <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        w_en  <= (cmd_op == OP_MAC);
                        addr  <= cmd_addr;
                        data  <= cmd_data;
                        state <= (cmd_op == OP_RSVD) ? ST_RESP : ST_PRECH;
                    end
                end
                ST_PRECH: begin
                    if (timer_done) state <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (timer_done) state <= (op_q == OP_WRITE) ? ST_RESP : ST_SENSE;
                end
                ST_SENSE: state <= ST_RESP;
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= (op_q == OP_RSVD);
                        rsp_data  <= (op_q == OP_MAC || op_q == OP_CAM) ? sa_out : '0;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
